// File: rtl/instr_mem_banked.sv
// Banked instruction memory with a registered fetch port and a runtime
// program mode. Fetches are served in RUN; loader writes are accepted in PROG.
module instr_mem_banked #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       NBANKS   = 2,
    parameter int unsigned       DEPTH    = 512,
    parameter logic [DATA_W-1:0] NOP_WORD = '0,
    localparam int unsigned      AW       = $clog2(DEPTH),
    localparam int unsigned      BW       = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic [BW-1:0]     bank_sel,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_fault,
    output logic              stall,
    input  logic              prog_start,
    input  logic              prog_done,
    input  logic              prog_we,
    input  logic [BW-1:0]     prog_bank,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [15:0]       prog_count,
    output logic              prog_err
);

    // Flat storage: bank b occupies words [b*DEPTH, (b+1)*DEPTH).
    localparam int unsigned MEM_WORDS = NBANKS * DEPTH;
    localparam int unsigned MW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // One extra bit so the range checks stay meaningful when DEPTH/NBANKS
    // are exact powers of two.
    localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH);
    localparam logic [BW:0] NBANKS_L = (BW + 1)'(NBANKS);

    typedef enum logic {
        RUN  = 1'b0,
        PROG = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                fault_q, fault_d;
    logic [15:0]         count_q, count_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem_q [MEM_WORDS];
    logic                mem_we;
    logic [MW-1:0]       mem_waddr;

    logic [AW-1:0]       fetch_idx;
    logic                fetch_bad;
    logic [MW-1:0]       fetch_addr;
    logic                wr_ok;

    // Fetch address decode and fault classification.
    always_comb begin
        fetch_idx  = pc[AW+1:2];
        fetch_bad  = (pc[1:0] != 2'b00)
                   | ((pc >> (AW + 2)) != '0)
                   | ({1'b0, fetch_idx} >= DEPTH_L)
                   | ({1'b0, bank_sel} >= NBANKS_L);
        fetch_addr = MW'(bank_sel) * MW'(DEPTH) + MW'(fetch_idx);
    end

    // Next state, fetch result and program-mode bookkeeping.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        fault_d   = 1'b0;
        count_d   = count_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = MW'(prog_bank) * MW'(DEPTH) + MW'(prog_addr);
        wr_ok     = ({1'b0, prog_bank} < NBANKS_L) && ({1'b0, prog_addr} < DEPTH_L);

        unique case (state_q)
            RUN: begin
                // A fetch on the prog_start edge is still served.
                if (fetch_req) begin
                    valid_d = 1'b1;
                    if (fetch_bad) begin
                        fault_d = 1'b1;
                        instr_d = NOP_WORD;
                    end else begin
                        instr_d = mem_q[fetch_addr];
                    end
                end
                if (prog_start) begin
                    state_d = PROG;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            PROG: begin
                // A write on the prog_done edge is still performed.
                if (prog_we) begin
                    if (wr_ok) begin
                        mem_we = 1'b1;
                        if (count_q != 16'hFFFF) begin
                            count_d = count_q + 16'd1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (prog_done) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Control and output registers; memory contents are outside reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Loader write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= prog_data;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign fetch_fault = fault_q;
    assign stall       = (state_q == PROG);
    assign prog_count  = count_q;
    assign prog_err    = err_q;

endmodule

// File: tb/tb_instr_mem_banked.sv
// Directed bench for instr_mem_banked: a default 2x512 instance and a
// 3x12 instance for bank/depth boundary cases that need representable
// out-of-range values.
module tb_instr_mem_banked;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: NBANKS=2, DEPTH=512
    logic        fetch_req, prog_start, prog_done, prog_we;
    logic [31:0] pc, prog_data;
    logic [0:0]  bank_sel, prog_bank;
    logic [8:0]  prog_addr;
    logic [31:0] instr;
    logic        instr_valid, fetch_fault, stall, prog_err;
    logic [15:0] prog_count;

    // Instance B: NBANKS=3, DEPTH=12
    logic        fetch_req_3, prog_start_3, prog_done_3, prog_we_3;
    logic [31:0] pc_3, prog_data_3;
    logic [1:0]  bank_sel_3, prog_bank_3;
    logic [3:0]  prog_addr_3;
    logic [31:0] instr_3;
    logic        instr_valid_3, fetch_fault_3, stall_3, prog_err_3;
    logic [15:0] prog_count_3;

    int n_asrt = 0;
    int n_fail = 0;

    instr_mem_banked #(
        .DATA_W(32), .ADDR_W(32), .NBANKS(2), .DEPTH(512), .NOP_WORD(32'h0)
    ) u_dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc),
        .bank_sel(bank_sel), .instr(instr), .instr_valid(instr_valid),
        .fetch_fault(fetch_fault), .stall(stall), .prog_start(prog_start),
        .prog_done(prog_done), .prog_we(prog_we), .prog_bank(prog_bank),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_count(prog_count), .prog_err(prog_err)
    );

    instr_mem_banked #(
        .DATA_W(32), .ADDR_W(32), .NBANKS(3), .DEPTH(12), .NOP_WORD(32'h0)
    ) u_dut3 (
        .clk(clk), .reset(reset), .fetch_req(fetch_req_3), .pc(pc_3),
        .bank_sel(bank_sel_3), .instr(instr_3), .instr_valid(instr_valid_3),
        .fetch_fault(fetch_fault_3), .stall(stall_3), .prog_start(prog_start_3),
        .prog_done(prog_done_3), .prog_we(prog_we_3), .prog_bank(prog_bank_3),
        .prog_addr(prog_addr_3), .prog_data(prog_data_3),
        .prog_count(prog_count_3), .prog_err(prog_err_3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        fetch_req = 0; prog_start = 0; prog_done = 0; prog_we = 0;
        pc = '0; prog_data = '0; bank_sel = '0; prog_bank = '0; prog_addr = '0;
        fetch_req_3 = 0; prog_start_3 = 0; prog_done_3 = 0; prog_we_3 = 0;
        pc_3 = '0; prog_data_3 = '0; bank_sel_3 = '0; prog_bank_3 = '0; prog_addr_3 = '0;

        // Reset state
        tick(); tick();
        chk("rst_instr", 64'(instr), 64'h0);
        chk("rst_valid", 64'(instr_valid), 64'h0);
        chk("rst_fault", 64'(fetch_fault), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_count", 64'(prog_count), 64'h0);
        chk("rst_err", 64'(prog_err), 64'h0);
        chk("rst_stall3", 64'(stall_3), 64'h0);
        reset = 1'b0;

        // Fetch from an unloaded bank: valid, no fault
        fetch_req = 1; pc = 32'h0; bank_sel = 0;
        tick();
        fetch_req = 0;
        chk("unl_valid", 64'(instr_valid), 64'h1);
        chk("unl_fault", 64'(fetch_fault), 64'h0);
        tick();
        chk("idle_valid", 64'(instr_valid), 64'h0);
        chk("idle_fault", 64'(fetch_fault), 64'h0);

        // Program two words
        prog_start = 1;
        tick();
        prog_start = 0;
        chk("prog_stall", 64'(stall), 64'h1);
        chk("prog_cnt0", 64'(prog_count), 64'h0);
        prog_we = 1; prog_bank = 0; prog_addr = 9'd3; prog_data = 32'h00A00093;
        tick();
        prog_bank = 1; prog_data = 32'h12345678;
        tick();
        prog_we = 0;
        chk("prog_cnt2", 64'(prog_count), 64'h2);
        chk("prog_err0", 64'(prog_err), 64'h0);
        prog_done = 1;
        tick();
        prog_done = 0;
        chk("done_stall", 64'(stall), 64'h0);

        // prog_we in RUN is ignored
        prog_we = 1; prog_bank = 0; prog_addr = 9'd3; prog_data = 32'hFFFFFFFF;
        tick();
        prog_we = 0;
        chk("run_we_cnt", 64'(prog_count), 64'h2);
        chk("run_we_err", 64'(prog_err), 64'h0);

        // Back-to-back fetches of the programmed words
        fetch_req = 1; pc = 32'hC; bank_sel = 0;
        tick();
        chk("rd_b0", 64'(instr), 64'h00A00093);
        chk("rd_b0_valid", 64'(instr_valid), 64'h1);
        chk("rd_b0_fault", 64'(fetch_fault), 64'h0);
        bank_sel = 1;
        tick();
        fetch_req = 0;
        chk("rd_b1", 64'(instr), 64'h12345678);
        chk("rd_b1_valid", 64'(instr_valid), 64'h1);
        tick();
        chk("hold_valid", 64'(instr_valid), 64'h0);
        chk("hold_instr", 64'(instr), 64'h12345678);

        // Fault cases
        fetch_req = 1; bank_sel = 0; pc = 32'h6;
        tick();
        chk("mis_instr", 64'(instr), 64'h0);
        chk("mis_fault", 64'(fetch_fault), 64'h1);
        chk("mis_valid", 64'(instr_valid), 64'h1);
        pc = 32'h800;
        tick();
        chk("depth_instr", 64'(instr), 64'h0);
        chk("depth_fault", 64'(fetch_fault), 64'h1);
        pc = 32'h8000_0000;
        tick();
        chk("hi_instr", 64'(instr), 64'h0);
        chk("hi_fault", 64'(fetch_fault), 64'h1);
        chk("hi_valid", 64'(instr_valid), 64'h1);
        pc = 32'h7FC; bank_sel = 1;
        tick();
        fetch_req = 0;
        chk("last_fault", 64'(fetch_fault), 64'h0);
        chk("last_valid", 64'(instr_valid), 64'h1);

        // Bank out of range on the 3-bank instance
        fetch_req_3 = 1; pc_3 = 32'h0; bank_sel_3 = 2'd3;
        tick();
        fetch_req_3 = 0;
        chk("bank_instr", 64'(instr_3), 64'h0);
        chk("bank_fault", 64'(fetch_fault_3), 64'h1);
        chk("bank_valid", 64'(instr_valid_3), 64'h1);

        // PROG on the 3x12 instance: dropped writes, fetch ignored
        prog_start_3 = 1;
        tick();
        prog_start_3 = 0;
        chk("p3_stall", 64'(stall_3), 64'h1);
        fetch_req_3 = 1; pc_3 = 32'h2C; bank_sel_3 = 2'd2;
        prog_we_3 = 1; prog_bank_3 = 2'd2; prog_addr_3 = 4'd11; prog_data_3 = 32'hCAFEF00D;
        tick();
        chk("p3_valid_a", 64'(instr_valid_3), 64'h0);
        chk("p3_cnt1", 64'(prog_count_3), 64'h1);
        chk("p3_err0", 64'(prog_err_3), 64'h0);
        prog_addr_3 = 4'd12;
        tick();
        chk("p3_addr_err", 64'(prog_err_3), 64'h1);
        chk("p3_addr_cnt", 64'(prog_count_3), 64'h1);
        chk("p3_valid_b", 64'(instr_valid_3), 64'h0);
        chk("p3_stall_b", 64'(stall_3), 64'h1);
        prog_bank_3 = 2'd3; prog_addr_3 = 4'd0;
        tick();
        chk("p3_bank_err", 64'(prog_err_3), 64'h1);
        chk("p3_bank_cnt", 64'(prog_count_3), 64'h1);
        prog_we_3 = 0; prog_done_3 = 1;
        tick();
        prog_done_3 = 0;
        chk("p3_done_stall", 64'(stall_3), 64'h0);
        chk("p3_done_valid", 64'(instr_valid_3), 64'h0);
        chk("p3_err_sticky", 64'(prog_err_3), 64'h1);
        tick();
        chk("p3_rd", 64'(instr_3), 64'hCAFEF00D);
        chk("p3_rd_fault", 64'(fetch_fault_3), 64'h0);
        pc_3 = 32'h30;
        tick();
        fetch_req_3 = 0;
        chk("p3_depth_instr", 64'(instr_3), 64'h0);
        chk("p3_depth_fault", 64'(fetch_fault_3), 64'h1);
        prog_start_3 = 1;
        tick();
        prog_start_3 = 0;
        chk("p3_reentry_err", 64'(prog_err_3), 64'h0);
        chk("p3_reentry_cnt", 64'(prog_count_3), 64'h0);
        prog_done_3 = 1;
        tick();
        prog_done_3 = 0;

        // prog_start on the same edge as a fetch; write on the prog_done edge
        fetch_req = 1; pc = 32'hC; bank_sel = 0; prog_start = 1;
        tick();
        prog_start = 0;
        chk("se_instr", 64'(instr), 64'h00A00093);
        chk("se_valid", 64'(instr_valid), 64'h1);
        chk("se_stall", 64'(stall), 64'h1);
        tick();
        fetch_req = 0;
        chk("se_held_valid", 64'(instr_valid), 64'h0);
        chk("se_held_stall", 64'(stall), 64'h1);
        prog_we = 1; prog_bank = 0; prog_addr = 9'd5; prog_data = 32'hDEADBEEF; prog_done = 1;
        tick();
        prog_we = 0; prog_done = 0;
        chk("de_stall", 64'(stall), 64'h0);
        chk("de_cnt", 64'(prog_count), 64'h1);
        fetch_req = 1; pc = 32'h14; bank_sel = 0;
        tick();
        fetch_req = 0;
        chk("de_rd", 64'(instr), 64'hDEADBEEF);
        chk("de_rd_valid", 64'(instr_valid), 64'h1);

        // Reset during PROG after five writes
        prog_start = 1;
        tick();
        prog_start = 0;
        prog_we = 1; prog_bank = 1;
        for (int i = 0; i < 5; i++) begin
            prog_addr = 9'(10 + i);
            prog_data = 32'h1000 + 32'(i);
            tick();
        end
        prog_we = 0;
        chk("mr_cnt5", 64'(prog_count), 64'h5);
        reset = 1;
        tick();
        chk("mr_stall", 64'(stall), 64'h0);
        chk("mr_cnt", 64'(prog_count), 64'h0);
        chk("mr_valid", 64'(instr_valid), 64'h0);
        // A fetch coinciding with reset produces no result
        fetch_req = 1; pc = 32'hC; bank_sel = 0;
        tick();
        fetch_req = 0;
        chk("rf_valid", 64'(instr_valid), 64'h0);
        chk("rf_instr", 64'(instr), 64'h0);
        reset = 0;
        bank_sel = 1; fetch_req = 1;
        for (int i = 0; i < 5; i++) begin
            pc = 32'((10 + i) * 4);
            tick();
            chk("mr_keep", 64'(instr), 64'h1000 + 64'(i));
        end
        fetch_req = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
